cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller for the multi-cycle RV32IM core.
- Sits between the core's word-wide load/store port and the block RAM. It is the initiator end of the RAM's mem_r/mem_w/ready/mem_data block protocol.
- Owns line storage (data, tag, valid, dirty) and sequences write-back and fill transactions on misses.

Parameters:
- ADDR_SIZE, 24, RAM block-address width; core byte address is ADDR_SIZE+OFF_BITS wide.
- BLOCK_BITS, 128, line/bus width; multiple of 32. Derived: OFF_BITS = log2(BLOCK_BITS/8).
- LINES, 16, number of lines; power of two. Derived: IDX_BITS = log2(LINES), TAG_BITS = ADDR_SIZE-IDX_BITS.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  access request, held until cpu_ready
- cpu_we  in  1  1=store, 0=load
- cpu_wstrb  in  4  byte enables for store
- cpu_addr  in  ADDR_SIZE+OFF_BITS  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_SIZE  RAM block address
- mem_r  out  1  block read request
- mem_w  out  1  block write request
- mem_ready  in  1  RAM idle/done
- mem_data  inout  BLOCK_BITS  block bus; driven only in WB states, else high-Z

Behaviour:
- Reset (async, rst_n=0):
  - All valid and dirty bits cleared.
  - cpu_ready=0, cpu_rdata=0, mem_r=0, mem_w=0, mem_addr=0, bus released.
  - State=IDLE.
- Address split: block address = cpu_addr[MSB:OFF_BITS]; index = low IDX_BITS of it; tag = upper TAG_BITS; word select = cpu_addr[OFF_BITS-1:2]. Word 0 is bits [31:0].
- IDLE:
  - If cpu_req=1 and mem_ready=1, latch addr/we/wstrb/wdata and go to TAG.
  - mem_ready=0 in IDLE (e.g. after mid-transaction reset) stalls acceptance.
- TAG, hit (valid and tag match):
  - Load: cpu_rdata = selected word.
  - Store: merge the wstrb bytes into the line and set dirty.
  - Pulse cpu_ready for one cycle, then go to IDLE.
  - Hit latency: request seen in cycle 0, cpu_ready=1 in cycle 2.
- TAG, miss:
  - If valid and dirty, go to WB_REQ.
  - Otherwise go to FILL_REQ.
- WB_REQ:
  - mem_addr={stored tag, index}, mem_w=1, drive line onto mem_data.
  - Stay until mem_ready=0, then go to WB_WAIT.
- WB_WAIT:
  - Keep mem_w, mem_addr and bus driven.
  - On mem_ready=1: mem_w=0, clear dirty, go to FILL_REQ.
- FILL_REQ:
  - Requires mem_r and mem_w low for at least 1 cycle since the last transaction, because RAM triggers on the request edge.
  - mem_addr=latched block address, mem_r=1, bus not driven.
  - On mem_ready=0, go to FILL_WAIT.
- FILL_WAIT:
  - On mem_ready=1: capture mem_data into the line, write tag, valid=1, dirty=0, mem_r=0, go to TAG. The access then completes as a hit.
- mem_r and mem_w are never both 1.
- The request strobe stays asserted until the RAM's ready-low acknowledge is seen, with no timeout.
- cpu_req inputs are ignored outside IDLE. The core must hold them stable until cpu_ready.
- Store with wstrb=0: treated as a hit/miss normally, line unchanged, dirty still set.
- Reset mid-transaction: the request is dropped immediately and the bus is released.

Optional Feature:
- CACHE_CTRL_STATS_EN defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - Each TAG entry from IDLE increments exactly one of them. Re-entry after a fill is not counted.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Cold load 0x0000_0010 (RAM block 1 = 0xDDDD..._CCCC..._BBBB..._AAAA...) -> one mem_r with mem_addr=1, no mem_w; cpu_rdata=0xAAAAAAAA; repeat load at 0x14 -> hit, cpu_ready 2 cycles after req, rdata=0xBBBBBBBB.
- Store 0x12345678 wstrb=4'b0011 to 0x10 after fill -> hit, no RAM traffic; load 0x10 returns 0xAAAA5678.
- Conflict load at 0x10+16*LINES (block 17) with line dirty -> mem_w with mem_addr=1 carrying merged line, then mem_r with mem_addr=17; RAM block 1 word 0 = 0xAAAA5678.
- Clean conflict eviction -> mem_r only, mem_w never asserted; mem_data high-Z throughout.
- rst_n low during FILL_WAIT -> mem_r=0 at once, all lines invalid; next access re-fills, and no request is issued until mem_ready=1.
- With CACHE_CTRL_STATS_EN: sequence miss, hit, hit, miss -> hit_count=2, miss_count=2.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate cache between the
// core's word load/store port and a block RAM (mem_r/mem_w/ready/mem_data).
// Optional macro CACHE_CTRL_STATS_EN adds hit_count/miss_count outputs.
module cache_ctrl #(
    parameter int ADDR_SIZE  = 24,
    parameter int BLOCK_BITS = 128,
    parameter int LINES      = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cpu_req,
    input  logic                                      cpu_we,
    input  logic [3:0]                                cpu_wstrb,
    input  logic [ADDR_SIZE+$clog2(BLOCK_BITS/8)-1:0] cpu_addr,
    input  logic [31:0]                               cpu_wdata,
    output logic [31:0]                               cpu_rdata,
    output logic                                      cpu_ready,
`ifdef CACHE_CTRL_STATS_EN
    output logic [31:0]                               hit_count,
    output logic [31:0]                               miss_count,
`endif
    output logic [ADDR_SIZE-1:0]                      mem_addr,
    output logic                                      mem_r,
    output logic                                      mem_w,
    input  logic                                      mem_ready,
    inout  wire  [BLOCK_BITS-1:0]                     mem_data
);
    localparam int OFF_BITS = $clog2(BLOCK_BITS / 8);
    localparam int ADDR_W   = ADDR_SIZE + OFF_BITS;
    localparam int IDX_BITS = $clog2(LINES);
    localparam int TAG_BITS = ADDR_SIZE - IDX_BITS;
    localparam int WORDS    = BLOCK_BITS / 32;
    localparam int WSEL_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {IDLE, TAG, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-3:0]     waddr_q, waddr_d;
    logic                  we_q, we_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  mem_r_q, mem_r_d;
    logic                  mem_w_q, mem_w_d;
    logic [ADDR_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;
    logic                  from_idle_q, from_idle_d;

    logic [BLOCK_BITS-1:0] data_q [LINES];
    logic [TAG_BITS-1:0]   tag_q  [LINES];

    logic [ADDR_SIZE-1:0]  blk;
    logic [IDX_BITS-1:0]   idx;
    logic [TAG_BITS-1:0]   tag;
    logic [WSEL_W-1:0]     word;
    logic [BLOCK_BITS-1:0] cur_line, merged, line_wdata;
    logic [31:0]           rd_word;
    logic                  hit, line_we, tag_we, cnt_hit, cnt_miss;
    logic                  unused_ok;

    assign blk       = waddr_q[ADDR_W-3 -: ADDR_SIZE];
    assign idx       = blk[IDX_BITS-1:0];
    assign tag       = blk[ADDR_SIZE-1:IDX_BITS];
    assign word      = WSEL_W'(waddr_q) & WSEL_W'(WORDS - 1);
    assign cur_line  = data_q[idx];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign unused_ok = &{1'b0, cpu_addr[1:0]};

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign mem_r     = mem_r_q;
    assign mem_w     = mem_w_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = (state_q == WB_REQ || state_q == WB_WAIT) ? cur_line
                                                                  : {BLOCK_BITS{1'bz}};

    // Word extract for loads and byte-merge of the store data into the line
    always_comb begin
        rd_word = cur_line[int'(word)*32 +: 32];
        merged  = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) merged[int'(word)*32 + b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    // Next-state, line update and bus strobe decisions
    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        mem_r_d     = mem_r_q;
        mem_w_d     = mem_w_q;
        mem_addr_d  = mem_addr_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        from_idle_d = 1'b0;
        line_we     = 1'b0;
        line_wdata  = mem_data;
        tag_we      = 1'b0;
        cnt_hit     = 1'b0;
        cnt_miss    = 1'b0;
        case (state_q)
            IDLE: begin
                // ready_q still high means the core has not yet dropped this request
                if (cpu_req && mem_ready && !ready_q) begin
                    waddr_d     = cpu_addr[ADDR_W-1:2];
                    we_d        = cpu_we;
                    wstrb_d     = cpu_wstrb;
                    wdata_d     = cpu_wdata;
                    from_idle_d = 1'b1;
                    state_d     = TAG;
                end
            end
            TAG: begin
                if (hit) begin
                    cnt_hit = from_idle_q;
                    if (we_q) begin
                        line_we      = 1'b1;
                        line_wdata   = merged;
                        dirty_d[idx] = 1'b1;
                    end else begin
                        rdata_d = rd_word;
                    end
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_miss = from_idle_q;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        mem_addr_d = {tag_q[idx], idx};
                        state_d    = WB_REQ;
                    end else begin
                        mem_addr_d = blk;
                        state_d    = FILL_REQ;
                    end
                end
            end
            WB_REQ: begin
                mem_w_d = 1'b1;
                if (mem_w_q && !mem_ready) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (mem_ready) begin
                    mem_w_d      = 1'b0;
                    dirty_d[idx] = 1'b0;
                    mem_addr_d   = blk;
                    state_d      = FILL_REQ;
                end
            end
            FILL_REQ: begin
                // First cycle here always has both strobes low, giving the RAM a fresh edge
                mem_r_d = 1'b1;
                if (mem_r_q && !mem_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (mem_ready) begin
                    line_we      = 1'b1;
                    tag_we       = 1'b1;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                    mem_r_d      = 1'b0;
                    state_d      = TAG;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and outputs, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_addr_q  <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            from_idle_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            mem_r_q     <= mem_r_d;
            mem_w_q     <= mem_w_d;
            mem_addr_q  <= mem_addr_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            from_idle_q <= from_idle_d;
        end
    end

    // Line data and tags need no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if (line_we) data_q[idx] <= line_wdata;
        if (tag_we)  tag_q[idx]  <= tag;
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // First-pass lookups only; wrap naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cnt_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (cnt_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = cnt_hit | cnt_miss;
`endif

endmodule
